// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data-memory port.
// Accepts one word load/store at a time over a valid/ready handshake, waits
// WAIT_CYCLES extra cycles, performs the access against a big-endian,
// byte-addressed store (addresses wrap modulo DEPTH_BYTES) and returns the
// result over a response handshake.
//
// Build option: define DMEM_ALIGN_CHECK_EN to fault word requests whose
// address is not 4-byte aligned (no write, resp_rdata=0, resp_err=1).
// Without it, resp_err is always 0 and misaligned words simply wrap.
//
// state  | meaning
// S_IDLE | ready for a request; req_ready=1
// S_WAIT | request latched; counting down wait states, access when count is 0
// S_RESP | response held on resp_*; waits for resp_ready
module dmem_responder #(
  parameter int DEPTH_BYTES = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          mem_q [DEPTH_BYTES];
  logic [7:0]          mem_d [DEPTH_BYTES];

  logic                access;
  logic                fault;
  logic [ADDR_W-1:0]   a0, a1, a2, a3;
  logic [31:0]         rd_word;

  // Byte addresses of the word; ADDR_W-bit arithmetic gives the wrap-around.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  assign rd_word = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault = (addr_q[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state, request latching and response formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          rdata_d = (wr_q || fault) ? 32'h0 : rd_word;
          err_d   = fault;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Store data merged into the byte array on the access edge.
  always_comb begin
    mem_d = mem_q;
    if (access && wr_q && !fault) begin
      mem_d[a0] = wdata_q[31:24];
      mem_d[a1] = wdata_q[23:16];
      mem_d[a2] = wdata_q[15:8];
      mem_d[a3] = wdata_q[7:0];
    end
  end

  // Control and response registers; reset wins over any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is not reset; a reset edge suppresses a pending store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

endmodule
